// File: rtl/i2c_reg_access_ctrl.sv
// i2c_reg_access_ctrl
// Sequences one register access (write or read) into i2c_master command and
// data-stream handshakes, and returns one response per request.
//
// State  | meaning
// -------+---------------------------------------------------------------
// IDLE      | waiting for a request (req_ready=1)
// W_CMD     | write: START, addr+W, write_multiple, STOP command
// W_REG     | write: register address byte (tlast=0)
// W_DATA    | write: data byte (tlast=1)
// R_CMDW    | read: START, addr+W command, no STOP
// R_REG     | read: register address byte (tlast=1)
// R_CMDR    | read: repeated START, addr+R, STOP command
// R_DATA    | read: accept one byte from the master
// WAIT_IDLE | wait for i2c_master to release the bus
// RESP      | present response until consumed
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   req_*                         request handshake and fields
//   resp_*                        response handshake, read data, error code
//   cmd_*                         i2c_master command interface
//   tx_*                          write data stream to i2c_master
//   rx_*                          read data stream from i2c_master
//   missed_ack, i2c_busy          i2c_master status
//   busy                          high whenever not IDLE

module i2c_reg_access_ctrl #(
    parameter int                       TIMEOUT_WIDTH  = 20,
    parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CYCLES = 20'hFFFFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_read,
    input  logic [6:0] req_dev_addr,
    input  logic [7:0] req_reg_addr,
    input  logic [7:0] req_wdata,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic [7:0] resp_rdata,
    output logic [1:0] resp_err,
    output logic [6:0] cmd_address,
    output logic       cmd_start,
    output logic       cmd_read,
    output logic       cmd_write,
    output logic       cmd_write_multiple,
    output logic       cmd_stop,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [7:0] tx_tdata,
    output logic       tx_tvalid,
    input  logic       tx_tready,
    output logic       tx_tlast,
    input  logic [7:0] rx_tdata,
    input  logic       rx_tvalid,
    output logic       rx_tready,
    input  logic       missed_ack,
    input  logic       i2c_busy,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE, W_CMD, W_REG, W_DATA, R_CMDW, R_REG, R_CMDR, R_DATA, WAIT_IDLE, RESP
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_NACK    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    // The watchdog counts down from TIMEOUT_CYCLES-1 so that a stalled state
    // is left exactly TIMEOUT_CYCLES cycles after the last reload.
    localparam logic [TIMEOUT_WIDTH-1:0] WDOG_LOAD = TIMEOUT_CYCLES - TIMEOUT_WIDTH'(1);

    state_t state_q, state_d;

    logic [6:0] dev_q;
    logic [7:0] reg_q;
    logic [7:0] wdata_q;
    logic       read_q;
    logic [7:0] rdata_q;
    logic       nack_q, nack_d;
    logic [1:0] wait_cnt_q;
    logic [TIMEOUT_WIDTH-1:0] wdog_q;

    logic req_hs, resp_hs, cmd_hs, tx_hs, rx_hs;
    logic active, timeout;

    // next-cycle values of the registered outputs
    logic       req_ready_d, resp_valid_d, busy_d;
    logic [7:0] resp_rdata_d;
    logic [1:0] resp_err_d;
    logic [6:0] cmd_address_d;
    logic       cmd_start_d, cmd_read_d, cmd_write_d, cmd_wm_d, cmd_stop_d, cmd_valid_d;
    logic [7:0] tx_tdata_d;
    logic       tx_tvalid_d, tx_tlast_d, rx_tready_d;

    assign req_hs  = req_valid & req_ready;
    assign resp_hs = resp_valid & resp_ready;
    assign cmd_hs  = cmd_valid & cmd_ready;
    assign tx_hs   = tx_tvalid & tx_tready;
    assign rx_hs   = rx_tvalid & rx_tready;
    assign active  = (state_q != IDLE) && (state_q != RESP);
    assign timeout = active && (wdog_q == '0);
    assign nack_d  = nack_q | (missed_ack & (state_q != IDLE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (req_hs)  state_d = req_read ? R_CMDW : W_CMD;
            W_CMD:     if (cmd_hs)  state_d = W_REG;
            W_REG:     if (tx_hs)   state_d = W_DATA;
            W_DATA:    if (tx_hs)   state_d = WAIT_IDLE;
            R_CMDW:    if (cmd_hs)  state_d = R_REG;
            R_REG:     if (tx_hs)   state_d = R_CMDR;
            R_CMDR:    if (cmd_hs)  state_d = R_DATA;
            R_DATA:    if (rx_hs)   state_d = WAIT_IDLE;
            WAIT_IDLE: if (wait_cnt_q == 2'd2 && !i2c_busy) state_d = RESP;
            RESP:      if (resp_hs) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        if (timeout) state_d = RESP;

        req_ready_d   = (state_d == IDLE);
        busy_d        = (state_d != IDLE);
        resp_valid_d  = 1'b0;
        resp_rdata_d  = '0;
        resp_err_d    = ERR_OK;
        cmd_valid_d   = 1'b0;
        cmd_start_d   = 1'b0;
        cmd_read_d    = 1'b0;
        cmd_write_d   = 1'b0;
        cmd_wm_d      = 1'b0;
        cmd_stop_d    = 1'b0;
        cmd_address_d = '0;
        tx_tvalid_d   = 1'b0;
        tx_tdata_d    = '0;
        tx_tlast_d    = 1'b0;
        rx_tready_d   = 1'b0;

        case (state_d)
            W_CMD: begin
                cmd_valid_d = 1'b1;
                cmd_start_d = 1'b1;
                cmd_wm_d    = 1'b1;
                cmd_stop_d  = 1'b1;
            end
            R_CMDW: begin
                cmd_valid_d = 1'b1;
                cmd_start_d = 1'b1;
                cmd_write_d = 1'b1;
            end
            R_CMDR: begin
                cmd_valid_d = 1'b1;
                cmd_start_d = 1'b1;
                cmd_read_d  = 1'b1;
                cmd_stop_d  = 1'b1;
            end
            W_REG: begin
                tx_tvalid_d = 1'b1;
                tx_tdata_d  = reg_q;
            end
            W_DATA: begin
                tx_tvalid_d = 1'b1;
                tx_tdata_d  = wdata_q;
                tx_tlast_d  = 1'b1;
            end
            R_REG: begin
                tx_tvalid_d = 1'b1;
                tx_tdata_d  = reg_q;
                tx_tlast_d  = 1'b1;
            end
            R_DATA: rx_tready_d = 1'b1;
            RESP: begin
                resp_valid_d = 1'b1;
                if (state_q == RESP) begin
                    resp_rdata_d = resp_rdata;
                    resp_err_d   = resp_err;
                end else begin
                    // timeout outranks a NACK seen earlier in the transaction
                    resp_err_d   = timeout ? ERR_TIMEOUT : (nack_d ? ERR_NACK : ERR_OK);
                    resp_rdata_d = (!timeout && !nack_d && read_q) ? rdata_q : 8'h00;
                end
            end
            default: ;
        endcase

        // the first command is launched on the accepting edge, before dev_q is valid
        if (cmd_valid_d) cmd_address_d = (state_q == IDLE) ? req_dev_addr : dev_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dev_q      <= '0;
            reg_q      <= '0;
            wdata_q    <= '0;
            read_q     <= 1'b0;
            rdata_q    <= '0;
            nack_q     <= 1'b0;
            wait_cnt_q <= '0;
            wdog_q     <= '0;
        end else begin
            if (req_hs) begin
                dev_q   <= req_dev_addr;
                reg_q   <= req_reg_addr;
                wdata_q <= req_wdata;
                read_q  <= req_read;
                nack_q  <= 1'b0;
            end else begin
                nack_q  <= nack_d;
            end
            if (rx_hs) rdata_q <= rx_tdata;

            if (state_d != state_q)    wait_cnt_q <= '0;
            else if (wait_cnt_q != 2'd2) wait_cnt_q <= wait_cnt_q + 2'd1;

            if ((state_d != state_q) || cmd_hs || tx_hs || rx_hs) wdog_q <= WDOG_LOAD;
            else if (active && wdog_q != '0)                       wdog_q <= wdog_q - TIMEOUT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready          <= 1'b0;
            busy               <= 1'b0;
            resp_valid         <= 1'b0;
            resp_rdata         <= '0;
            resp_err           <= '0;
            cmd_valid          <= 1'b0;
            cmd_start          <= 1'b0;
            cmd_read           <= 1'b0;
            cmd_write          <= 1'b0;
            cmd_write_multiple <= 1'b0;
            cmd_stop           <= 1'b0;
            cmd_address        <= '0;
            tx_tvalid          <= 1'b0;
            tx_tdata           <= '0;
            tx_tlast           <= 1'b0;
            rx_tready          <= 1'b0;
        end else begin
            req_ready          <= req_ready_d;
            busy               <= busy_d;
            resp_valid         <= resp_valid_d;
            resp_rdata         <= resp_rdata_d;
            resp_err           <= resp_err_d;
            cmd_valid          <= cmd_valid_d;
            cmd_start          <= cmd_start_d;
            cmd_read           <= cmd_read_d;
            cmd_write          <= cmd_write_d;
            cmd_write_multiple <= cmd_wm_d;
            cmd_stop           <= cmd_stop_d;
            cmd_address        <= cmd_address_d;
            tx_tvalid          <= tx_tvalid_d;
            tx_tdata           <= tx_tdata_d;
            tx_tlast           <= tx_tlast_d;
            rx_tready          <= rx_tready_d;
        end
    end

endmodule

// File: tb/tb_i2c_reg_access_ctrl.sv
// Directed bench for i2c_reg_access_ctrl with a small i2c_master responder.
module tb_i2c_reg_access_ctrl;

    localparam int         TW = 20;
    localparam logic [TW-1:0] TC = 20'd100;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, req_read;
    logic [6:0] req_dev_addr;
    logic [7:0] req_reg_addr, req_wdata;
    logic       resp_valid, resp_ready;
    logic [7:0] resp_rdata;
    logic [1:0] resp_err;
    logic [6:0] cmd_address;
    logic       cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop;
    logic       cmd_valid, cmd_ready;
    logic [7:0] tx_tdata;
    logic       tx_tvalid, tx_tready, tx_tlast;
    logic [7:0] rx_tdata;
    logic       rx_tvalid, rx_tready;
    logic       missed_ack, i2c_busy, busy;

    i2c_reg_access_ctrl #(.TIMEOUT_WIDTH(TW), .TIMEOUT_CYCLES(TC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_read(req_read),
        .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .cmd_address(cmd_address), .cmd_start(cmd_start), .cmd_read(cmd_read),
        .cmd_write(cmd_write), .cmd_write_multiple(cmd_write_multiple), .cmd_stop(cmd_stop),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tlast(tx_tlast),
        .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready),
        .missed_ack(missed_ack), .i2c_busy(i2c_busy), .busy(busy)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    // responder configuration, set by the stimulus
    logic       nack_mode  = 1'b0;
    logic [7:0] slave_byte = 8'h00;

    // handshakes sampled at the active edge, consumed on the following negedge
    logic        cmd_hs_s = 1'b0, tx_hs_s = 1'b0, rx_hs_s = 1'b0;
    logic [11:0] cmd_s = '0;
    logic [8:0]  tx_s  = '0;
    int          resp_n = 0;

    always @(posedge clk) begin
        cmd_hs_s <= cmd_valid && cmd_ready && !rst;
        cmd_s    <= {cmd_address, cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop};
        tx_hs_s  <= tx_tvalid && tx_tready && !rst;
        tx_s     <= {tx_tdata, tx_tlast};
        rx_hs_s  <= rx_tvalid && rx_tready && !rst;
        if (resp_valid && resp_ready && !rst) resp_n <= resp_n + 1;
    end

    logic [11:0] cmd_log [64];
    logic [8:0]  tx_log  [64];
    int          cmd_n = 0, tx_n = 0, busy_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            rx_tvalid  = 1'b0;
            rx_tdata   = 8'h00;
            missed_ack = 1'b0;
            i2c_busy   = 1'b0;
            busy_cnt   = 0;
        end else begin
            missed_ack = 1'b0;
            if (cmd_hs_s) begin
                if (cmd_n < 64) cmd_log[cmd_n] = cmd_s;
                cmd_n++;
                busy_cnt = 4;
                if (nack_mode) missed_ack = 1'b1;
                if (cmd_s[3]) begin
                    rx_tvalid = 1'b1;
                    rx_tdata  = slave_byte;
                end
            end
            if (tx_hs_s) begin
                if (tx_n < 64) tx_log[tx_n] = tx_s;
                tx_n++;
                busy_cnt = 4;
            end
            if (rx_hs_s) begin
                rx_tvalid = 1'b0;
                busy_cnt  = 4;
            end
            if (busy_cnt != 0) busy_cnt--;
            i2c_busy = (busy_cnt != 0) || rx_tvalid;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input logic rd, input logic [6:0] dev, input logic [7:0] rg,
                            input logic [7:0] wd);
        logic got;
        @(negedge clk);
        req_read = rd; req_dev_addr = dev; req_reg_addr = rg; req_wdata = wd;
        req_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (req_ready) begin got = 1'b1; break; end
            @(negedge clk);
        end
        check("req_ready_wait", {31'd0, got}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        // scramble inputs to prove the fields were captured
        req_valid = 1'b0; req_read = ~rd;
        req_dev_addr = 7'h7F; req_reg_addr = 8'hFF; req_wdata = 8'hFF;
    endtask

    task automatic get_resp(output logic [7:0] rdata, output logic [1:0] err);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (resp_valid) begin got = 1'b1; break; end
            @(negedge clk);
        end
        check("resp_wait", {31'd0, got}, 32'd1);
        rdata = resp_rdata;
        err   = resp_err;
        if (resp_ready) @(negedge clk);
    endtask

    function automatic logic [11:0] cmdv(input logic [6:0] a, input logic s, input logic r,
                                         input logic w, input logic wm, input logic p);
        return {a, s, r, w, wm, p};
    endfunction

    logic [7:0] rd;
    logic [1:0] er;
    int c0, t0, r0, n;
    logic got;

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_read = 1'b0; req_dev_addr = '0; req_reg_addr = '0; req_wdata = '0;
        resp_ready = 1'b1; cmd_ready = 1'b1; tx_tready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_outs", {resp_valid, cmd_valid, tx_tvalid, rx_tready, busy,
                           cmd_start, cmd_stop, tx_tlast}, 32'd0);
        check("rst_data", {resp_rdata, resp_err, cmd_address, tx_tdata}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

        // register write, slave ACKs
        c0 = cmd_n; t0 = tx_n; r0 = resp_n;
        send_req(1'b0, 7'h70, 8'h12, 8'h37);
        get_resp(rd, er);
        check("wr_err", {30'd0, er}, 32'd0);
        check("wr_rdata", {24'd0, rd}, 32'd0);
        check("wr_cmd_count", cmd_n - c0, 32'd1);
        check("wr_cmd", {20'd0, cmd_log[c0]}, {20'd0, cmdv(7'h70, 1, 0, 0, 1, 1)});
        check("wr_tx_count", tx_n - t0, 32'd2);
        check("wr_tx0", {23'd0, tx_log[t0]}, {23'd0, 8'h12, 1'b0});
        check("wr_tx1", {23'd0, tx_log[t0+1]}, {23'd0, 8'h37, 1'b1});
        check("wr_resp_count", resp_n - r0, 32'd1);
        check("wr_req_ready_back", {31'd0, req_ready}, 32'd1);

        // register read, slave returns 7B
        slave_byte = 8'h7B;
        c0 = cmd_n; t0 = tx_n; r0 = resp_n;
        send_req(1'b1, 7'h70, 8'h05, 8'h00);
        get_resp(rd, er);
        check("rd_err", {30'd0, er}, 32'd0);
        check("rd_rdata", {24'd0, rd}, 32'h7B);
        check("rd_cmd_count", cmd_n - c0, 32'd2);
        check("rd_cmd0", {20'd0, cmd_log[c0]}, {20'd0, cmdv(7'h70, 1, 0, 1, 0, 0)});
        check("rd_cmd1", {20'd0, cmd_log[c0+1]}, {20'd0, cmdv(7'h70, 1, 1, 0, 0, 1)});
        check("rd_tx_count", tx_n - t0, 32'd1);
        check("rd_tx0", {23'd0, tx_log[t0]}, {23'd0, 8'h05, 1'b1});
        check("rd_resp_count", resp_n - r0, 32'd1);

        // write to an absent device: NACK, sequence still completes with STOP
        nack_mode = 1'b1;
        c0 = cmd_n; t0 = tx_n;
        send_req(1'b0, 7'h01, 8'h20, 8'h55);
        get_resp(rd, er);
        nack_mode = 1'b0;
        check("nack_err", {30'd0, er}, 32'd1);
        check("nack_rdata", {24'd0, rd}, 32'd0);
        check("nack_cmd", {20'd0, cmd_log[c0]}, {20'd0, cmdv(7'h01, 1, 0, 0, 1, 1)});
        check("nack_tx_count", tx_n - t0, 32'd2);
        check("nack_req_ready", {31'd0, req_ready}, 32'd1);

        // command never accepted: watchdog drops cmd_valid after TC cycles
        cmd_ready = 1'b0;
        send_req(1'b0, 7'h70, 8'h12, 8'h37);
        n = 0;
        while (cmd_valid && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("to_cmd_valid_cycles", n, 32'd100);
        get_resp(rd, er);
        check("to_err", {30'd0, er}, 32'd2);
        check("to_rdata", {24'd0, rd}, 32'd0);
        cmd_ready = 1'b1;
        send_req(1'b0, 7'h70, 8'h13, 8'h44);
        get_resp(rd, er);
        check("after_to_err", {30'd0, er}, 32'd0);

        // back-pressured response holds stable
        slave_byte = 8'hA5;
        resp_ready = 1'b0;
        send_req(1'b1, 7'h70, 8'h06, 8'h00);
        get_resp(rd, er);
        check("hold_first_rdata", {24'd0, rd}, 32'hA5);
        got = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!(resp_valid === 1'b1 && resp_rdata === 8'hA5 && resp_err === 2'd0 &&
                  req_ready === 1'b0)) got = 1'b0;
        end
        check("hold_stable", {31'd0, got}, 32'd1);
        resp_ready = 1'b1;
        @(negedge clk);
        check("hold_release_valid", {31'd0, resp_valid}, 32'd0);
        check("hold_release_req_ready", {31'd0, req_ready}, 32'd1);

        // reset asserted while the register byte is pending
        tx_tready = 1'b0;
        r0 = resp_n;
        send_req(1'b0, 7'h70, 8'h12, 8'h37);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (tx_tvalid) begin got = 1'b1; break; end
            @(negedge clk);
        end
        check("rst_mid_reach_wreg", {31'd0, got}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_ctrl", {req_ready, resp_valid, cmd_valid, tx_tvalid, rx_tready, busy,
                               tx_tlast, cmd_start}, 32'd0);
        check("rst_mid_data", {tx_tdata, cmd_address, resp_rdata, resp_err}, 32'd0);
        tx_tready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp_valid || cmd_valid || tx_tvalid || busy) got = 1'b1;
        end
        check("rst_mid_no_stale", {31'd0, got}, 32'd0);
        check("rst_mid_resp_count", resp_n - r0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/i2c_reg_access_ctrl.md
Name: i2c_reg_access_ctrl

Overview:
Sequencer in front of i2c_master. It turns one register-access request (device address, 8-bit register address, write data, read/write flag) into the i2c_master command and data-stream handshakes. A write is START, addr+W, reg, data, STOP. A read is START, addr+W, reg, then repeated START, addr+R, data, STOP. It returns one response per request carrying read data and an error code (NACK or timeout), so firmware and other blocks need not drive i2c_master's command interface directly.

Parameters:
TIMEOUT_WIDTH, 20, width of the watchdog counter.
TIMEOUT_CYCLES, 20'hFFFFF, clk cycles without progress before a transaction is aborted with a timeout; must fit in TIMEOUT_WIDTH.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_read  in  1  1 = register read, 0 = register write
req_dev_addr  in  7  I2C device address
req_reg_addr  in  8  register address byte
req_wdata  in  8  write data; ignored for reads
resp_valid  out  1  response valid
resp_ready  in  1  response consumer ready
resp_rdata  out  8  read data; 0 for writes and for errored reads
resp_err  out  2  0 = OK, 1 = NACK seen, 2 = timeout
cmd_address  out  7  to i2c_master s_axis_cmd_address
cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop  out  1 each  to i2c_master command flags
cmd_valid  out  1  command valid
cmd_ready  in  1  command ready
tx_tdata  out  8  to i2c_master s_axis_data_tdata
tx_tvalid  out  1  data valid
tx_tready  in  1  data ready
tx_tlast  out  1  last byte of a write_multiple burst
rx_tdata  in  8  from i2c_master m_axis_data_tdata
rx_tvalid  in  1  read data valid
rx_tready  out  1  read data ready
missed_ack  in  1  i2c_master missed_ack pulse
i2c_busy  in  1  i2c_master busy
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: req_ready, resp_valid, cmd_valid, tx_tvalid, rx_tready and busy are 0. All data and flag outputs are 0. State is IDLE.
- req_ready = 1 exactly when state is IDLE and not in reset, so it rises on the first clk after reset releases.
- All outputs are registered.
- Request fields are captured on the accepting edge; inputs may change afterwards.
- States: IDLE, W_CMD, W_REG, W_DATA, R_CMDW, R_REG, R_CMDR, R_DATA, WAIT_IDLE, RESP.
- Write path: IDLE → W_CMD → W_REG → W_DATA → WAIT_IDLE.
  - W_CMD: cmd_valid=1, address=dev, start=1, write_multiple=1, stop=1. Advance on cmd_valid&cmd_ready.
  - W_REG: tx_tdata=reg, tlast=0. Advance on tx handshake.
  - W_DATA: tx_tdata=wdata, tlast=1. Advance on tx handshake.
- Read path: IDLE → R_CMDW → R_REG → R_CMDR → R_DATA → WAIT_IDLE.
  - R_CMDW: start=1, write=1, stop=0.
  - R_REG: tx_tdata=reg, tlast=1.
  - R_CMDR: start=1, read=1, stop=1.
  - R_DATA: rx_tready=1; on rx handshake latch rx_tdata.
- Each valid is asserted on entering its state and dropped in the cycle after its handshake. A valid never falls without a handshake, except on timeout.
- WAIT_IDLE: wait until i2c_busy=0, sampled at least 2 cycles after entry, then go to RESP.
- RESP: resp_valid=1 and hold until resp_ready, then IDLE. req_ready returns 1 on the next cycle, so back-to-back requests have a minimum 1-cycle gap.
- NACK:
  - missed_ack in any non-IDLE state sets a sticky err flag.
  - The sequence still runs to completion, so STOP is issued and the bus is released.
  - resp_err=1 and resp_rdata=0.
- Timeout:
  - The watchdog reloads on entering each state and on every handshake, and counts only in non-IDLE, non-RESP states.
  - On reaching TIMEOUT_CYCLES: drop cmd_valid, tx_tvalid and rx_tready; go to RESP with resp_err=2.
  - Timeout has priority over NACK.
- missed_ack in the same cycle as a handshake: both take effect.
- Reset mid-transaction: immediate return to reset values; no response is issued.

Test Plan:
- Write dev=7'h70, reg=8'h12, wdata=8'h37 with slave ACKing → command seen once with start=1, write_multiple=1, stop=1; tx bytes 12 (tlast 0) then 37 (tlast 1); one response with err=0, rdata=00.
- Read dev=7'h70, reg=8'h05, slave returns 8'h7B → commands are write (stop=0) then read (start=1, stop=1); tx byte 05 with tlast=1; response rdata=7B, err=0.
- Write to absent dev=7'h01 (no ACK) → missed_ack pulses; STOP still issued; response err=1, rdata=00; req_ready returns to 1.
- Hold cmd_ready=0 with TIMEOUT_CYCLES=100 → cmd_valid drops after 100 cycles; response err=2; next request completes normally.
- Hold resp_ready=0 for 20 cycles after a read of 8'hA5 → resp_valid and rdata=A5 stay stable; req_ready stays 0 until the handshake.
- Assert rst during W_REG → all outputs return to 0 immediately; after release req_ready=1 and no stale response appears.
